updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised modulo up/down counter with a built-in clock-enable prescaler, synchronous load, wrap or saturate mode, and optional seven-segment hex outputs. It replaces the fixed 8-bit toggle-flip-flop counter wherever a counter drives board displays. Typical uses are lab-style displays running at a divided rate, event counters, and countdown timers.

## Interface
Parameters:
- `WIDTH`, 8: counter width in bits; legal range 1..32.
- `MODULUS`, 256: count range is 0..MODULUS-1; legal range 2..2^WIDTH.
- `PRESCALE`, 1: number of enabled clocks per count step; must be ≥1.

Ports:
- `clk` input, 1 bit: rising-edge clock. This is the only clock.
- `clear` input, 1 bit: reset; synchronous, active-high.
- `enable` input, 1 bit: advances the prescaler. While low, the prescaler and count hold.
- `up` input, 1 bit: 1 counts up, 0 counts down. Sampled on step cycles.
- `sat` input, 1 bit: 1 saturates at the terminal value; 0 wraps.
- `load` input, 1 bit: synchronous load of `load_value`.
- `load_value` input, WIDTH bits: value for `load`.
- `count` output, WIDTH bits: registered count value.
- `tick` output, 1 bit: registered pulse, high for one cycle after each step.
- `tc` output, 1 bit: registered pulse, high for one cycle after a step taken from the terminal value.
- `hex` output, 7·NDIG bits, where NDIG = (WIDTH+3)/4: active-low segments. Digit k occupies bits [7k+6:7k] and displays count[4k+3:4k]. This port exists only with `UMC_HEX_EN`.

## Operation
- Prescaler `pcnt` ranges over 0..PRESCALE-1 and is internal. A step cycle is any cycle with `enable`=1 and `pcnt`=PRESCALE-1. On a step cycle `pcnt` returns to 0; on other enabled cycles it increments by 1. With PRESCALE=1, every enabled cycle is a step cycle.
- Priority per edge is clear > load > step > hold.
- Clear: `count`=0, `pcnt`=0, `tick`=0, `tc`=0.
- Load:
  - `count` takes `load_value`. If `load_value` ≥ MODULUS, `count` takes MODULUS-1 instead.
  - `pcnt` resets to 0.
  - `tick` and `tc` are 0 on the next cycle.
  - A step that coincides with a load is discarded.
- Up step:
  - If `count` < MODULUS-1, `count` increments by 1.
  - If `count` = MODULUS-1, `count` becomes 0 when `sat`=0 and holds when `sat`=1.
- Down step:
  - If `count` > 0, `count` decrements by 1.
  - If `count` = 0, `count` becomes MODULUS-1 when `sat`=0 and holds when `sat`=1.
- The terminal value is MODULUS-1 when `up`=1 and 0 when `up`=0. `tc` asserts after any step taken at the terminal value, including a saturated hold.
- `tick` asserts after every step, including saturated holds.
- Arithmetic is internal at WIDTH+1 bits, so MODULUS=2^WIDTH never overflows when comparing.
- Changing `up` or `sat` between steps takes effect at the next step. It does not disturb `pcnt`.
- Asserting `clear` mid-prescale discards any partial prescale count.

## Timing
- All outputs are registered; `hex` is a combinational decode of the registered `count`.
- Reset values: `count`=0, `tick`=0, `tc`=0, and `hex` shows "0" on every digit (7'b1000000 each).
- Latency:
  - `count` updates on the edge that ends a step cycle.
  - `tick` and `tc` are valid during the cycle after that edge, coincident with the new `count`.
- Pulse shape: `tick` and `tc` are never high longer than one cycle when PRESCALE>1. With PRESCALE=1 and `enable` held high, they may be high on consecutive cycles.
- Throughput: at most one step per PRESCALE enabled clocks.

## Configuration
- Macro `UMC_HEX_EN`.
- Defined: the `hex` port and NDIG per-digit 0–F decoders are present. The digits use active-low segment order a..g, with a at bit 0.
- Undefined: the `hex` port and decoders are absent. Counter behaviour and timing are identical.

## Test plan
- Reset and hex decode: WIDTH=8, MODULUS=256, PRESCALE=1; hold `clear` for 2 cycles, then `enable`=1, `up`=1 for 300 cycles.
  - After reset: `count`=0 and `hex`=14'h2040.
  - `count` reaches 255, then 0 on the next step.
  - `tc`=1 only in the cycle where `count` returns to 0.
  - After 0xA5, `hex`={7'h08,7'h12}.
- Prescale: PRESCALE=4, `enable`=1; toggle `enable` low for 3 cycles mid-period.
  - `count` advances exactly once per 4 enabled clocks.
  - `tick` pulses width 1, coincident with each `count` change.
- Down-count in both modes: MODULUS=10; `load` 2, then `up`=0.
  - With `sat`=0: `count` follows 1, 0, 9, with `tc` after the 0→9 step.
  - With `sat`=1: `count` holds at 0, and `tc` pulses on each further step.
- Load priority and clamp: `load_value`=200 with MODULUS=150, with `load` asserted in the same cycle as a step.
  - `count`=149, `tick`=0, and `pcnt` restarts, so the next step comes 4 enabled clocks later when PRESCALE=4.
- Clear mid-operation: with `count`=7 and `pcnt`=2, assert `clear` together with `load`=1.
  - Next cycle: `count`=0, `tick`=0, `tc`=0.
  - The first step occurs after PRESCALE full enabled clocks.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Modulo up/down counter with a clock-enable prescaler, synchronous load
//   (clamped to MODULUS-1), and wrap or saturate at the terminal value.
//   Optional seven-segment hex outputs are built when UMC_HEX_EN is defined.
//
// Parameters
//   WIDTH    counter width (1..32)
//   MODULUS  count range 0..MODULUS-1 (2..2^WIDTH)
//   PRESCALE enabled clocks per count step (>=1)
//
// Ports
//   clk        rising-edge clock
//   clear      synchronous active-high reset
//   enable     advances the prescaler; prescaler and count hold while low
//   up         1 = count up, 0 = count down (sampled on step cycles)
//   sat        1 = saturate at terminal value, 0 = wrap
//   load       synchronous load of load_value (beats any coincident step)
//   load_value value for load
//   count      registered count
//   tick       one-cycle pulse after each step
//   tc         one-cycle pulse after a step taken from the terminal value
//   hex        (UMC_HEX_EN only) active-low segments, 7 bits per nibble,
//              segment a at bit 0 of each digit
module updown_mod_counter #(
    parameter int          WIDTH    = 8,
    parameter longint      MODULUS  = 256,
    parameter int          PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
`ifdef UMC_HEX_EN
    ,
    output logic [7*((WIDTH+3)/4)-1:0] hex
`endif
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    // Terminal value held at WIDTH+1 bits so MODULUS = 2^WIDTH compares cleanly.
    localparam logic [WIDTH:0] TOP = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_W = TOP[WIDTH-1:0];

    logic [PW-1:0]    pcnt_reg;
    logic [WIDTH-1:0] count_reg;
    logic             tick_reg;
    logic             tc_reg;

    logic             step;
    logic             at_top;
    logic             at_zero;
    logic             at_term;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic [PW-1:0]    pcnt_next;

    assign step    = enable && (pcnt_reg == PLAST);
    assign at_top  = ({1'b0, count_reg} == TOP);
    assign at_zero = (count_reg == '0);
    assign at_term = up ? at_top : at_zero;

    assign load_clamped = ({1'b0, load_value} > TOP) ? TOP_W : load_value;
    assign pcnt_next    = step ? '0 : pcnt_reg + PW'(1);

    always_comb begin
        count_next = count_reg;
        if (up) begin
            if (at_top)
                count_next = sat ? count_reg : '0;
            else
                count_next = count_reg + WIDTH'(1);
        end else begin
            if (at_zero)
                count_next = sat ? count_reg : TOP_W;
            else
                count_next = count_reg - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            count_reg <= '0;
            pcnt_reg  <= '0;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else if (load) begin
            // A step landing on the same edge is discarded and the
            // prescale period restarts from the load.
            count_reg <= load_clamped;
            pcnt_reg  <= '0;
            tick_reg  <= 1'b0;
            tc_reg    <= 1'b0;
        end else begin
            tick_reg <= step;
            tc_reg   <= step && at_term;
            if (enable)
                pcnt_reg <= pcnt_next;
            if (step)
                count_reg <= count_next;
        end
    end

    assign count = count_reg;
    assign tick  = tick_reg;
    assign tc    = tc_reg;

`ifdef UMC_HEX_EN
    localparam int NDIG = (WIDTH + 3) / 4;

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Zero-pad so a partial top nibble decodes with leading zeros.
    logic [4*NDIG-1:0] count_pad;
    assign count_pad = (4*NDIG)'(count_reg);

    for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
        assign hex[7*gi +: 7] = seg7(count_pad[4*gi +: 4]);
    end
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

    localparam int NI = 4;
    localparam int WS [NI] = '{8, 8, 4, 4};
    localparam int MS [NI] = '{256, 150, 10, 16};
    localparam int PS [NI] = '{1, 4, 2, 3};

    typedef struct {
        int cnt;
        int pc;
        bit tick;
        bit tc;
    } state_t;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b0;
    logic       up = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;

    int         act_cnt  [NI];
    logic       act_tick [NI];
    logic       act_tc   [NI];
`ifdef UMC_HEX_EN
    int         act_hex  [NI];
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = WS[gi];
        logic [W-1:0] c;
        logic         tk;
        logic         t;
`ifdef UMC_HEX_EN
        logic [7*((W+3)/4)-1:0] hx;
`endif
        updown_mod_counter #(
            .WIDTH(W), .MODULUS(MS[gi]), .PRESCALE(PS[gi])
        ) dut (
            .clk(clk), .clear(clear), .enable(enable), .up(up), .sat(sat),
            .load(load), .load_value(load_value[W-1:0]),
            .count(c), .tick(tk), .tc(t)
`ifdef UMC_HEX_EN
            , .hex(hx)
`endif
        );
        assign act_cnt[gi]  = int'(c);
        assign act_tick[gi] = tk;
        assign act_tc[gi]   = t;
`ifdef UMC_HEX_EN
        assign act_hex[gi]  = int'(hx);
`endif
    end

    // Reference model: plain integer arithmetic on count and prescale phase.
    state_t st [NI];
    state_t exp_q [NI][$];
    bit     running = 0;
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;

    function automatic state_t model_next(input int i, input state_t s);
        state_t n;
        int m, p, lv;
        m = MS[i];
        p = PS[i];
        lv = int'(load_value) % (1 << WS[i]);
        n = s;
        n.tick = 0;
        n.tc = 0;
        if (clear) begin
            n.cnt = 0;
            n.pc = 0;
        end else if (load) begin
            n.cnt = (lv >= m) ? m - 1 : lv;
            n.pc = 0;
        end else if (enable) begin
            if (s.pc == p - 1) begin
                n.pc = 0;
                n.tick = 1;
                if (up) begin
                    if (s.cnt == m - 1) begin
                        n.tc = 1;
                        n.cnt = sat ? s.cnt : 0;
                    end else n.cnt = s.cnt + 1;
                end else begin
                    if (s.cnt == 0) begin
                        n.tc = 1;
                        n.cnt = sat ? 0 : m - 1;
                    end else n.cnt = s.cnt - 1;
                end
            end else n.pc = s.pc + 1;
        end
        return n;
    endfunction

`ifdef UMC_HEX_EN
    function automatic int hex_of(input int w, input int v);
        logic [6:0] seg [16];
        int h;
        seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        h = 0;
        for (int k = 0; k < (w + 3) / 4; k++)
            h = h | (int'(seg[(v >> (4 * k)) & 15]) << (7 * k));
        return h;
    endfunction
`endif

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input logic c, input logic l, input logic [7:0] lv,
                         input logic en, input logic u, input logic s);
        @(negedge clk);
        clear = c; load = l; load_value = lv; enable = en; up = u; sat = s;
        running = 1;
        for (int i = 0; i < NI; i++) begin
            st[i] = model_next(i, st[i]);
            exp_q[i].push_back(st[i]);
        end
    endtask

    // Monitor: every cycle each counter presents count/tick/tc.
    initial begin
        state_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (running) begin
                for (int i = 0; i < NI; i++) begin
                    total++;
                    if (exp_q[i].size() == 0) begin
                        bad++;
                        $display("FAIL underflow inst%0d cyc%0d: got no expectation, required one", i, cyc);
                    end else begin
                        e = exp_q[i].pop_front();
                        if (act_cnt[i] != e.cnt || act_tick[i] !== e.tick || act_tc[i] !== e.tc) begin
                            bad++;
                            $display("FAIL count/tick/tc inst%0d cyc%0d: got %0d/%b/%b required %0d/%b/%b",
                                     i, cyc, act_cnt[i], act_tick[i], act_tc[i], e.cnt, e.tick, e.tc);
                        end
`ifdef UMC_HEX_EN
                        total++;
                        if (act_hex[i] != hex_of(WS[i], e.cnt)) begin
                            bad++;
                            $display("FAIL hex inst%0d cyc%0d: got %h required %h",
                                     i, cyc, act_hex[i], hex_of(WS[i], e.cnt));
                        end
`endif
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NI; i++) st[i] = '{0, 0, 0, 0};
        // Reset, then free-run up through a full wrap of the 8-bit counter.
        drive(1, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 1, 0);
        for (int n = 0; n < 300; n++) drive(0, 0, 0, 1, 1, 0);
        // Enable gap mid-prescale.
        for (int n = 0; n < 3; n++) drive(0, 0, 0, 0, 1, 0);
        for (int n = 0; n < 10; n++) drive(0, 0, 0, 1, 1, 0);
        // Down count from 2: wrap mode, then saturate mode.
        drive(0, 1, 8'd2, 0, 0, 0);
        for (int n = 0; n < 16; n++) drive(0, 0, 0, 1, 0, 0);
        drive(0, 1, 8'd2, 0, 0, 1);
        for (int n = 0; n < 16; n++) drive(0, 0, 0, 1, 0, 1);
        // Clamped load coinciding with steps, then recovery.
        drive(0, 1, 8'd200, 1, 1, 0);
        for (int n = 0; n < 10; n++) drive(0, 0, 0, 1, 1, 0);
        // Clear together with load mid-prescale.
        drive(0, 1, 8'd7, 0, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1, 0);
        drive(1, 1, 8'd9, 1, 1, 0);
        for (int n = 0; n < 12; n++) drive(0, 0, 0, 1, 1, 0);
        // Randomized mix.
        for (int n = 0; n < 3000; n++) begin
            logic c, l, en, u, s;
            c  = ($urandom_range(0, 199) == 0);
            l  = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 9) < 8);
            u  = (n % 400 < 200) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            s  = ((n / 100) % 3 == 1);
            drive(c, l, 8'($urandom_range(0, 255)), en, u, s);
        end
        drive(0, 0, 0, 0, 1, 0);
        @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
